fsm: RTL and testbench
======================

// Module: fsm
// PURPOSE
//   Controller for a 4-slot smart parking lot, sitting between the gate sensors and the display/gate actuator.
//   Tracks slot occupancy and assigns each entering car the lowest-numbered free slot.
//   Frees the slot named on exit and drives the gate-open pulse, full flag, free count and last slot.
// PARAMETERS
//   none -- slot count fixed at 4 by port widths (localparam NUM_SLOTS = 4)
// PORTS
//   clk           in   1  system clock, rising-edge active
//   reset         in   1  synchronous, active-high reset
//   entry_signal  in   1  car requesting entry this cycle
//   exit_signal   in   1  car leaving this cycle
//   exit_slot     in   2  slot index (0..3) of the leaving car, valid with exit_signal
//   is_open       out  1  gate-open pulse, 1 cycle per accepted event
//   is_full       out  1  1 when all 4 slots are occupied
//   spots         out  4  occupancy bitmap, bit i = 1 -> slot i occupied
//   capacity      out  3  number of free slots, 0..4
//   location      out  2  slot index of the most recent accepted event
// BEHAVIOUR
//   - Single clock domain; one clock, reset synchronous and active-high.
//   - All outputs are registered; inputs are sampled at posedge clk and results appear the same edge (1-cycle latency).
//   - Reset (reset=1 at posedge), dominating all inputs: spots=4'b0000, capacity=4, location=0, is_full=0, is_open=0, state=IDLE.
//   - States:
//     - IDLE: gate closed.
//     - OPEN: gate open for exactly 1 cycle.
//     - OPEN returns to IDLE on the next edge unless another accepted event occurs, which keeps it in OPEN.
//   - Valid exit: exit_signal=1 and spots[exit_slot]=1. It clears spots[exit_slot] and sets location=exit_slot.
//   - Invalid exit (slot already empty) is ignored: no state change, is_open not asserted.
//   - Entry is evaluated on the bitmap AFTER any valid exit in the same cycle.
//     - If a free slot exists: set the lowest free index k, location=k, gate opens.
//     - If none is free: entry refused, is_open=0, location unchanged.
//   - Simultaneous valid exit + entry on a full lot admits the car into the freed slot.
//     capacity stays 0 and location = that slot.
//   - is_open=1 for the cycle following any accepted entry or valid exit, else 0.
//   - capacity = 4 - popcount(next spots); is_full = (next capacity == 0). Both are registered alongside spots.
//   - capacity never underflows below 0 nor exceeds 4; spots only changes via accepted events.
//   - reset asserted mid-operation clears everything on that edge; prior occupancy is lost.
//   - entry_signal=exit_signal=0 holds all state; is_open returns to 0.
// TESTING
//   1. Reset, then 4 consecutive entries:
//      -> location 0,1,2,3; spots 0001,0011,0111,1111; capacity 3,2,1,0; is_full=1 after 4th; is_open=1 each.
//   2. Lot full, 5th entry -> spots=1111, capacity=0, location stays 3, is_open=0, is_full=1.
//   3. Full lot, exit slot 1 -> spots=1101, capacity=1, location=1, is_open=1, is_full=0.
//      Next entry -> slot 1, spots=1111.
//   4. Exit on empty slot 2 from spots=0011 -> no change, is_open=0, capacity=2.
//   5. Full lot, entry + exit slot 2 same cycle -> spots=1111, location=2, capacity=0, is_open=1.
//   6. Reset asserted with spots=0111 -> next edge spots=0000, capacity=4, location=0, is_open=0, is_full=0.

Source files
------------

// File: rtl/fsm.sv
// Parking-lot controller for four slots: tracks occupancy, assigns the lowest
// free slot on entry, frees the named slot on exit, and pulses the gate open.
module fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_signal,
  input  logic       exit_signal,
  input  logic [1:0] exit_slot,
  output logic       is_open,
  output logic       is_full,
  output logic [3:0] spots,
  output logic [2:0] capacity,
  output logic [1:0] location
);

  localparam logic [2:0] NUM_SLOTS = 3'd4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OPEN = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_spots;
  logic [2:0] r_capacity;
  logic [1:0] r_location;
  logic       r_is_full;

  logic       w_exit_ok;
  logic       w_entry_ok;
  logic       w_accept;
  logic [3:0] w_after_exit;
  logic [3:0] w_spots_nxt;
  logic [1:0] w_loc_nxt;
  logic [1:0] w_free_idx;
  logic [2:0] w_cap_nxt;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Lowest clear bit of the bitmap; caller only uses it when one exists.
  function automatic logic [1:0] lowest_free(input logic [3:0] occ);
    casez (occ)
      4'b???0: lowest_free = 2'd0;
      4'b??01: lowest_free = 2'd1;
      4'b?011: lowest_free = 2'd2;
      4'b0111: lowest_free = 2'd3;
      default: lowest_free = 2'd0;
    endcase
  endfunction

  // Next occupancy, location and gate state; entry sees the bitmap after any exit.
  always_comb begin
    w_exit_ok    = 1'b0;
    w_entry_ok   = 1'b0;
    w_after_exit = r_spots;
    w_spots_nxt  = r_spots;
    w_loc_nxt    = r_location;
    w_free_idx   = 2'd0;
    w_state_nxt  = IDLE;

    w_exit_ok = exit_signal && r_spots[exit_slot];
    if (w_exit_ok) begin
      w_after_exit[exit_slot] = 1'b0;
      w_loc_nxt               = exit_slot;
    end else begin
      w_after_exit = r_spots;
    end

    w_free_idx  = lowest_free(w_after_exit);
    w_entry_ok  = entry_signal && (w_after_exit != 4'b1111);
    w_spots_nxt = w_after_exit;
    if (w_entry_ok) begin
      w_spots_nxt[w_free_idx] = 1'b1;
      w_loc_nxt               = w_free_idx;
    end else begin
      w_spots_nxt = w_after_exit;
    end

    w_accept = w_exit_ok || w_entry_ok;

    case (r_state)
      IDLE:    w_state_nxt = w_accept ? OPEN : IDLE;
      OPEN:    w_state_nxt = w_accept ? OPEN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_cap_nxt = NUM_SLOTS - popcount4(w_spots_nxt);

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_spots    <= 4'b0000;
      r_capacity <= NUM_SLOTS;
      r_location <= 2'd0;
      r_is_full  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_spots    <= w_spots_nxt;
      r_capacity <= w_cap_nxt;
      r_location <= w_loc_nxt;
      r_is_full  <= (w_cap_nxt == 3'd0);
    end
  end

  assign is_open  = (r_state == OPEN);
  assign is_full  = r_is_full;
  assign spots    = r_spots;
  assign capacity = r_capacity;
  assign location = r_location;

endmodule

// File: tb/tb_fsm.sv
// Directed table-driven bench for the parking-lot controller, plus a short
// hand-written sequence for an exit-plus-entry into a lower free slot.
module tb_fsm;

  logic       clk;
  logic       reset;
  logic       entry_signal;
  logic       exit_signal;
  logic [1:0] exit_slot;
  logic       is_open;
  logic       is_full;
  logic [3:0] spots;
  logic [2:0] capacity;
  logic [1:0] location;

  int total = 0;
  int bad   = 0;

  fsm dut (
    .clk          (clk),
    .reset        (reset),
    .entry_signal (entry_signal),
    .exit_signal  (exit_signal),
    .exit_slot    (exit_slot),
    .is_open      (is_open),
    .is_full      (is_full),
    .spots        (spots),
    .capacity     (capacity),
    .location     (location)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       ent;
    logic       ext;
    logic [1:0] slot;
    logic       e_open;
    logic       e_full;
    logic [3:0] e_spots;
    logic [2:0] e_cap;
    logic [1:0] e_loc;
  } vec_t;

  vec_t vecs[19];

  task automatic step(input logic rst, input logic ent, input logic ext, input logic [1:0] slot);
    @(negedge clk);
    reset        = rst;
    entry_signal = ent;
    exit_signal  = ext;
    exit_slot    = slot;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic e_open, input logic e_full,
                       input logic [3:0] e_spots, input logic [2:0] e_cap, input logic [1:0] e_loc);
    total++;
    if (is_open !== e_open) begin
      bad++;
      $display("FAIL %s is_open got=%b exp=%b", name, is_open, e_open);
    end
    total++;
    if (is_full !== e_full) begin
      bad++;
      $display("FAIL %s is_full got=%b exp=%b", name, is_full, e_full);
    end
    total++;
    if (spots !== e_spots) begin
      bad++;
      $display("FAIL %s spots got=%b exp=%b", name, spots, e_spots);
    end
    total++;
    if (capacity !== e_cap) begin
      bad++;
      $display("FAIL %s capacity got=%0d exp=%0d", name, capacity, e_cap);
    end
    total++;
    if (location !== e_loc) begin
      bad++;
      $display("FAIL %s location got=%0d exp=%0d", name, location, e_loc);
    end
  endtask

  initial begin
    reset        = 1'b1;
    entry_signal = 1'b0;
    exit_signal  = 1'b0;
    exit_slot    = 2'd0;

    //           name            rst   ent   ext   slot  open  full  spots    cap   loc
    vecs[0]  = '{"reset",        1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 3'd4, 2'd0};
    vecs[1]  = '{"entry0",       1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0001, 3'd3, 2'd0};
    vecs[2]  = '{"entry1",       1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0011, 3'd2, 2'd1};
    vecs[3]  = '{"entry2",       1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0111, 3'd1, 2'd2};
    vecs[4]  = '{"entry3",       1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 4'b1111, 3'd0, 2'd3};
    vecs[5]  = '{"entry_full",   1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 4'b1111, 3'd0, 2'd3};
    vecs[6]  = '{"exit1",        1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 4'b1101, 3'd1, 2'd1};
    vecs[7]  = '{"refill1",      1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 4'b1111, 3'd0, 2'd1};
    vecs[8]  = '{"swap2",        1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 4'b1111, 3'd0, 2'd2};
    vecs[9]  = '{"idle_full",    1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 4'b1111, 3'd0, 2'd2};
    vecs[10] = '{"reset_full",   1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 3'd4, 2'd0};
    vecs[11] = '{"entry0b",      1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0001, 3'd3, 2'd0};
    vecs[12] = '{"entry1b",      1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0011, 3'd2, 2'd1};
    vecs[13] = '{"exit_empty2",  1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 4'b0011, 3'd2, 2'd1};
    vecs[14] = '{"entry2b",      1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 4'b0111, 3'd1, 2'd2};
    vecs[15] = '{"reset_dom",    1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 3'd4, 2'd0};
    vecs[16] = '{"exit_empty0",  1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 4'b0000, 3'd4, 2'd0};
    vecs[17] = '{"ent_badexit3", 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 4'b0001, 3'd3, 2'd0};
    vecs[18] = '{"swap0",        1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0001, 3'd3, 2'd0};

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].rst, vecs[i].ent, vecs[i].ext, vecs[i].slot);
      check(vecs[i].name, vecs[i].e_open, vecs[i].e_full, vecs[i].e_spots,
            vecs[i].e_cap, vecs[i].e_loc);
    end

    // Fill to 1111, empty slot 0, then exit slot 3 with entry: car lands in slot 0.
    step(1'b0, 1'b1, 1'b0, 2'd0);
    check("seq_fill1", 1'b1, 1'b0, 4'b0011, 3'd2, 2'd1);
    step(1'b0, 1'b1, 1'b0, 2'd0);
    check("seq_fill2", 1'b1, 1'b0, 4'b0111, 3'd1, 2'd2);
    step(1'b0, 1'b1, 1'b0, 2'd0);
    check("seq_fill3", 1'b1, 1'b1, 4'b1111, 3'd0, 2'd3);
    step(1'b0, 1'b0, 1'b1, 2'd0);
    check("seq_exit0", 1'b1, 1'b0, 4'b1110, 3'd1, 2'd0);
    step(1'b0, 1'b1, 1'b1, 2'd3);
    check("seq_x3_ent", 1'b1, 1'b0, 4'b0111, 3'd1, 2'd0);
    step(1'b0, 1'b0, 1'b0, 2'd0);
    check("seq_idle", 1'b0, 1'b0, 4'b0111, 3'd1, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
